// File: rtl/mod_instr_fetch_queue_pkg.sv
// Shared instruction-fetch definitions: queue sizing, entry layout and fetch FSM states.
package mod_instr_fetch_queue_pkg;

    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned INSTR_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               end_flag;
    } fq_entry_t;

endpackage

// File: rtl/mod_fetch_fifo.sv
// Circular buffer of fetched entries with push/pop/flush and a combinational head read.
module mod_fetch_fifo
    import mod_instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  logic      flush_i,
    input  fq_entry_t wdata_i,
    output fq_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;
    fq_entry_t     mem_q [DEPTH];

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = 1'b0;
        do_pop   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Flush realigns the read side onto the write side so stale slots are simply skipped.
        if (flush_i) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            do_pop  = pop_i && !empty_o;
            do_push = push_i && (!full_o || do_pop);
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/mod_instr_fetch_queue.sv
// Instruction prefetch queue: fetches ahead from the ROM and presents the entry matching pc.
module mod_instr_fetch_queue
    import mod_instr_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = IFQ_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        hold,
    output logic [29:0] rom_address,
    input  logic [31:0] rom_instruction,
    input  logic        rom_mem_end,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        mem_end,
    output logic        fetch_stall
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         push, pop, redirect, head_hit;
    logic         fifo_full, fifo_empty;
    fq_entry_t    head, wentry;

    assign wentry = '{pc: fetch_pc_q, instr: rom_instruction, end_flag: rom_mem_end};

    mod_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i (wentry),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            state_d    = S_FETCH;
            fetch_pc_d = pc;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d    = S_FETCH;
                    fetch_pc_d = pc;
                end
                S_FETCH: begin
                    if (push) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (rom_mem_end) state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        head_hit = !fifo_empty && (head.pc == pc);
        // A pc mismatch flushes regardless of hold; the empty case compares against the next fetch address.
        redirect = (state_q != S_IDLE) &&
                   (fifo_empty ? (fetch_pc_q != pc) : (head.pc != pc));
        pop         = head_hit && !hold;
        push        = (state_q == S_FETCH) && !redirect && (!fifo_full || pop);
        instr_valid = head_hit;
        fetch_stall = !head_hit;
        instruction = head_hit ? head.instr : '0;
        mem_end     = head_hit && head.end_flag;
        rom_address = fetch_pc_q[31:2];
    end

endmodule

// File: tb/tb_mod_instr_fetch_queue.sv
// Scoreboard bench: a processor model walks pc and retires entries against a ROM-derived expectation queue.
module tb_mod_instr_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic        end_f;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        hold;
    logic [29:0] rom_address;
    logic [31:0] rom_instruction;
    logic        rom_mem_end;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        mem_end;
    logic        fetch_stall;

    logic [31:0] rom_mem [64];
    logic        end_en;
    logic [29:0] end_word;
    exp_t        sb_q [$];
    int          vectors = 0;
    int          errors  = 0;
    int          stalls;

    mod_instr_fetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .hold            (hold),
        .rom_address     (rom_address),
        .rom_instruction (rom_instruction),
        .rom_mem_end     (rom_mem_end),
        .instruction     (instruction),
        .instr_valid     (instr_valid),
        .mem_end         (mem_end),
        .fetch_stall     (fetch_stall)
    );

    assign rom_instruction = (rom_address < 30'd64) ? rom_mem[rom_address[5:0]] : 32'h0;
    assign rom_mem_end     = end_en && (rom_address == end_word);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input logic [31:0] p);
        exp_t e;
        e.instr = (p < 32'd256) ? rom_mem[p[7:2]] : 32'h0;
        e.end_f = end_en && ({2'b00, p[31:2]} == {2'b00, end_word});
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk(tag, instruction, e.instr);
            chk({tag, "_end"}, 32'(mem_end), 32'(e.end_f));
        end
    endtask

    // Retire n sequential instructions; pc advances just after each popping edge.
    task automatic consume(input int n, input int budget, output int st);
        int done = 0;
        st = 0;
        while (done < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (instr_valid) begin
                pop_check("retire");
                @(posedge clk);
                #1;
                pc = pc + 32'd4;
                sb_push(pc);
                done++;
            end else begin
                st++;
            end
        end
        if (done < n) chk("consume_timeout", 32'(done), 32'(n));
    endtask

    initial begin
        reset    = 1'b0;
        pc       = RESET_PC;
        hold     = 1'b0;
        end_en   = 1'b0;
        end_word = '0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h1000_0000 | (32'(i) << 8) | 32'(i);
        rom_mem[0] = 32'h2008_0005;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_stall", 32'(fetch_stall), 32'd1);
        chk("rst_instr", instruction, 32'd0);
        chk("rst_mend",  32'(mem_end), 32'd0);
        chk("rst_addr",  32'(rom_address), {2'b00, RESET_PC[31:2]});

        // Release: valid exactly two edges later, then one instruction per clock
        reset = 1'b1;
        sb_push(pc);
        @(posedge clk); #1;
        chk("lat_edge1", 32'(fetch_stall), 32'd1);
        @(posedge clk); #1;
        chk("lat_edge2", 32'(instr_valid), 32'd1);
        consume(8, 20, stalls);
        chk("stream_stalls", 32'(stalls), 32'd0);

        // Hold at pc=8: head frozen, queue saturates, fetch stops at 24
        sb_q.delete();
        pc   = 32'd8;
        hold = 1'b1;
        sb_push(pc);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) chk("hold_head", instruction, rom_mem[2]);
        end
        chk("hold_fetch_addr", 32'(rom_address), 32'd6);
        @(posedge clk); #1;
        hold = 1'b0;
        consume(6, 10, stalls);
        chk("hold_resume_stalls", 32'(stalls), 32'd0);

        // Branch from head pc=12 to 40 while hold is high
        sb_q.delete();
        hold = 1'b1;
        pc   = 32'd12;
        sb_push(pc);
        repeat (2) @(posedge clk);
        #1;
        pop_check("br_head");
        pc = 32'd40;
        sb_push(pc);
        @(negedge clk);
        chk("br_stall0", 32'(fetch_stall), 32'd1);
        @(posedge clk); #1;
        chk("br_stall1", 32'(fetch_stall), 32'd1);
        @(posedge clk); #1;
        chk("br_valid", 32'(instr_valid), 32'd1);
        hold = 1'b0;
        consume(2, 6, stalls);
        chk("br_after_stalls", 32'(stalls), 32'd0);

        // End of program at word 5
        sb_q.delete();
        end_en   = 1'b1;
        end_word = 30'd5;
        pc       = 32'd0;
        sb_push(pc);
        consume(6, 20, stalls);
        chk("me_lat_stalls", 32'(stalls), 32'd2);
        sb_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("me_no_push", 32'(instr_valid), 32'd0);
        end
        chk("me_fetch_addr", 32'(rom_address), 32'd6);
        @(posedge clk); #1;
        end_en = 1'b0;
        pc     = 32'd0;
        sb_push(pc);
        consume(3, 12, stalls);
        chk("me_restart_stalls", 32'(stalls), 32'd2);

        // Asynchronous reset pulse with a full queue
        hold = 1'b1;
        repeat (6) @(negedge clk);
        chk("full_valid", 32'(instr_valid), 32'd1);
        chk("full_fetch_addr", 32'(rom_address), 32'd7);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_stall", 32'(fetch_stall), 32'd1);
        chk("arst_instr", instruction, 32'd0);
        #2;
        reset = 1'b1;
        hold  = 1'b0;
        pc    = RESET_PC;
        sb_q.delete();
        sb_push(pc);
        @(posedge clk); #1;
        chk("arst_edge1", 32'(fetch_stall), 32'd1);
        @(posedge clk); #1;
        chk("arst_edge2", 32'(instr_valid), 32'd1);
        consume(3, 8, stalls);
        chk("arst_stream_stalls", 32'(stalls), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mod_instr_fetch_queue.md
MOD_INSTR_FETCH_QUEUE -- requirements
Module: mod_instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, minimum 2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, fetch address loaded at reset.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-005 Port pc, input, 32, processor's current program counter (the address whose instruction it wants).
REQ-006 Port hold, input, 1, processor stall; 1 = do not consume the head entry this cycle.
REQ-007 Port rom_address, output, 30, word address to the instruction ROM (fetch_pc[31:2]).
REQ-008 Port rom_instruction, input, 32, combinational ROM read data for rom_address.
REQ-009 Port rom_mem_end, input, 1, combinational ROM end-of-program flag for rom_address.
REQ-010 Port instruction, output, 32, head-entry instruction presented to the processor.
REQ-011 Port instr_valid, output, 1, 1 = instruction corresponds to pc and may be executed.
REQ-012 Port mem_end, output, 1, head-entry end flag, qualified by instr_valid.
REQ-013 Port fetch_stall, output, 1, equals NOT instr_valid; processor holds while 1.

Function
REQ-014 Each entry SHALL store {pc[31:0], instruction[31:0], end_flag}; storage is a circular buffer with wr_ptr, rd_ptr and a count of width clog2(DEPTH)+1.
REQ-015 States SHALL be S_IDLE, S_FETCH, S_DONE; S_IDLE -> S_FETCH on the first rising edge after reset deasserts, loading fetch_pc <= pc.
REQ-016 In S_FETCH, each edge where (count < DEPTH) or a pop occurs in the same cycle SHALL push {fetch_pc, rom_instruction, rom_mem_end} and set fetch_pc <= fetch_pc + 4 (32-bit wrap-around modulo 2^32).
REQ-017 A push with rom_mem_end = 1 SHALL move S_FETCH -> S_DONE; S_DONE performs no further pushes.
REQ-018 instr_valid SHALL be 1 iff count != 0 and head.pc == pc; instruction and mem_end reflect the head entry (instruction = 0, mem_end = 0 when instr_valid = 0).
REQ-019 Pop SHALL occur on an edge where instr_valid = 1 and hold = 0; push and pop in the same edge leave count unchanged.
REQ-020 Redirect condition: state != S_IDLE and ((count != 0 and head.pc != pc) or (count == 0 and fetch_pc != pc)).
REQ-021 On a redirect edge: flush (count <= 0, rd_ptr <= wr_ptr), fetch_pc <= pc, state <= S_FETCH, no push; redirect takes priority over push and pop.
REQ-022 Latency: after reset release or redirect, instr_valid SHALL assert after exactly two rising edges (one to load fetch_pc, one to push).
REQ-023 Sequential pc stream with hold = 0 and a full/refilling queue SHALL yield instr_valid = 1 every cycle (throughput one instruction per clock).
REQ-024 hold = 1 SHALL freeze the head; queue fills to DEPTH and pushes stop while full; no entry is lost or duplicated.
REQ-025 hold is ignored for redirect: a pc mismatch flushes even while hold = 1.

Reset
REQ-026 While reset = 0: state = S_IDLE, fetch_pc = RESET_PC, count = 0, pointers = 0; outputs instr_valid = 0, fetch_stall = 1, mem_end = 0, instruction = 0, rom_address = RESET_PC[31:2].
REQ-027 Reset asserted mid-operation SHALL discard all entries immediately (asynchronously); storage contents need not be cleared.

Structure
REQ-028 State encodings, DEPTH default and entry field widths SHALL reside in the shared instruction-defines package.
REQ-029 The circular buffer SHALL be one sub-module, mod_fetch_fifo (push/pop/flush, full/empty, head read), instantiated once.

Verification
REQ-030 Reset release with pc = 0, ROM word0 = 32'h2008_0005: instr_valid = 1 after 2 edges, instruction = 32'h2008_0005.
REQ-031 Sequential pc 0,4,8,...,28, hold = 0: eight consecutive cycles with instr_valid = 1 and matching ROM words.
REQ-032 hold = 1 for 6 cycles at pc = 8: count saturates at 4, instruction stays word2, fetch_pc stops at 24; releasing hold resumes in order.
REQ-033 Branch: head.pc = 12 while pc jumps to 40: queue flushed, fetch_stall = 1 for 2 cycles, then instruction = ROM word10.
REQ-034 ROM word5 has mem_end = 1: no pushes beyond pc 20, mem_end = 1 when pc = 20 is at head; redirect to pc = 0 restarts fetching.
REQ-035 Reset pulsed low for 3 ns mid-stream with queue full: instr_valid = 0 immediately, 2 edges after release instruction = word at RESET_PC.
